// File: rtl/me_pkg.sv
// Shared constants, FSM state type and candidate naming for the fractional ME sequencer.
package me_pkg;

   localparam int ROWS      = 8;
   localparam int NCAND     = 25;
   localparam int RSAD_W    = 11;
   localparam int BSAD_W    = 14;
   localparam int AW        = 8;
   localparam int IDX_W     = 5;
   localparam int PIX_W     = 64;
   localparam int FETCH_CYC = ROWS + 2;

   typedef enum logic [2:0] {IDLE, FETCH, ACCUM, SEARCH, DONE} state_t;

   // Candidate index = vertical line * 5 + horizontal offset (H/Q = half/quarter left, F = full).
   localparam logic [IDX_W-1:0] UH_H = 5'd0,  UH_Q = 5'd1,  UH_F = 5'd2,  UH_RQ = 5'd3,  UH_RH = 5'd4;
   localparam logic [IDX_W-1:0] UQ_H = 5'd5,  UQ_Q = 5'd6,  UQ_F = 5'd7,  UQ_RQ = 5'd8,  UQ_RH = 5'd9;
   localparam logic [IDX_W-1:0] CT_H = 5'd10, CT_Q = 5'd11, CT_F = 5'd12, CT_RQ = 5'd13, CT_RH = 5'd14;
   localparam logic [IDX_W-1:0] LQ_H = 5'd15, LQ_Q = 5'd16, LQ_F = 5'd17, LQ_RQ = 5'd18, LQ_RH = 5'd19;
   localparam logic [IDX_W-1:0] LH_H = 5'd20, LH_Q = 5'd21, LH_F = 5'd22, LH_RQ = 5'd23, LH_RH = 5'd24;

endpackage

// File: rtl/frac_me_ctrl_if.sv
// Line-buffer, datapath and result signals of the fractional ME sequencer.
// Handshakes: line-buffer reads are strobe-only (data one cycle later, no back-pressure);
// the result follows valid/ready: res_valid rises and stays high with best_idx/best_sad
// stable until the cycle res_valid && res_ready is seen, which completes the transfer.
interface frac_me_ctrl_if;
   import me_pkg::*;

   logic                    start;
   logic [AW-1:0]           ref_base;
   logic [AW-1:0]           org_base;
   logic                    ref_rd_en;
   logic [AW-1:0]           ref_rd_addr;
   logic [PIX_W-1:0]        ref_rd_data;
   logic                    org_rd_en;
   logic [AW-1:0]           org_rd_addr;
   logic [PIX_W-1:0]        org_rd_data;
   logic [PIX_W-1:0]        cur_upper_pix;
   logic [PIX_W-1:0]        cur_middle_pix;
   logic [PIX_W-1:0]        cur_lower_pix;
   logic [PIX_W-1:0]        org_pix;
   logic                    win_valid;
   logic [NCAND*RSAD_W-1:0] row_sad;
   logic                    row_sad_valid;
   logic                    busy;
   logic                    res_valid;
   logic                    res_ready;
   logic [IDX_W-1:0]        best_idx;
   logic [BSAD_W-1:0]       best_sad;
   state_t                  dbg_state;

   modport master (
      input  start, ref_base, org_base, ref_rd_data, org_rd_data, row_sad, row_sad_valid, res_ready,
      output ref_rd_en, ref_rd_addr, org_rd_en, org_rd_addr, cur_upper_pix, cur_middle_pix,
             cur_lower_pix, org_pix, win_valid, busy, res_valid, best_idx, best_sad, dbg_state
   );

   modport slave (
      output start, ref_base, org_base, ref_rd_data, org_rd_data, row_sad, row_sad_valid, res_ready,
      input  ref_rd_en, ref_rd_addr, org_rd_en, org_rd_addr, cur_upper_pix, cur_middle_pix,
             cur_lower_pix, org_pix, win_valid, busy, res_valid, best_idx, best_sad, dbg_state
   );

endinterface

// File: rtl/sad_acc_bank.sv
// Bank of per-candidate block-SAD accumulators: synchronous clear, parallel add, indexed read.
module sad_acc_bank
   import me_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    add_en,
   input  logic [NCAND*RSAD_W-1:0] row_sad,
   input  logic [IDX_W-1:0]        rd_idx,
   output logic [BSAD_W-1:0]       rd_sad
);

   localparam logic [IDX_W-1:0] LAST_CAND = IDX_W'(NCAND - 1);

   logic [BSAD_W-1:0] acc_q [NCAND];

   // Clear wins over add; ROWS row SADs cannot overflow BSAD_W.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int k = 0; k < NCAND; k++) acc_q[k] <= '0;
      end else if (add_en) begin
         for (int k = 0; k < NCAND; k++)
            acc_q[k] <= acc_q[k] + BSAD_W'(row_sad[k*RSAD_W +: RSAD_W]);
      end
   end

   assign rd_sad = (rd_idx <= LAST_CAND) ? acc_q[rd_idx] : '0;

endmodule

// File: rtl/frac_me_ctrl.sv
// Fractional ME pass sequencer: fetches rows, builds the 3-row window, accumulates
// candidate SADs and serially picks the lowest-index minimum.
module frac_me_ctrl
   import me_pkg::*;
(
   input logic            clk,
   input logic            rst,
   frac_me_ctrl_if.master bus
);

   localparam logic [3:0]       FETCH_LAST = 4'(FETCH_CYC - 1);
   localparam logic [3:0]       ORG_FIRST  = 4'd2;
   localparam logic [3:0]       ROWS_CNT   = 4'(ROWS);
   localparam logic [3:0]       ROWS_LAST  = 4'(ROWS - 1);
   localparam logic [IDX_W-1:0] LAST_CAND  = IDX_W'(NCAND - 1);

   state_t            state_q, state_d;
   logic [3:0]        fetch_cnt_q, pulse_cnt_q;
   logic [AW-1:0]     ref_base_q, org_base_q;
   logic              ref_vld_q, org_vld_q, win_valid_q;
   logic [PIX_W-1:0]  upper_q, middle_q, lower_q, org_pix_q;
   logic [IDX_W-1:0]  srch_idx_q, best_idx_q;
   logic [BSAD_W-1:0] best_sad_q, acc_rd;
   logic              acc_clr, acc_add;

   assign acc_add = bus.row_sad_valid && (state_q == FETCH || state_q == ACCUM)
                    && (pulse_cnt_q != ROWS_CNT);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d         = state_q;
      acc_clr         = 1'b0;
      bus.ref_rd_en   = 1'b0;
      bus.ref_rd_addr = '0;
      bus.org_rd_en   = 1'b0;
      bus.org_rd_addr = '0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = FETCH;
               acc_clr = 1'b1;
            end
         end
         FETCH: begin
            bus.ref_rd_en   = 1'b1;
            bus.ref_rd_addr = ref_base_q + AW'(fetch_cnt_q);
            // Original rows trail by two so row r lines up with reference rows r..r+2.
            if (fetch_cnt_q >= ORG_FIRST) begin
               bus.org_rd_en   = 1'b1;
               bus.org_rd_addr = org_base_q + AW'(fetch_cnt_q - ORG_FIRST);
            end
            if (fetch_cnt_q == FETCH_LAST) state_d = ACCUM;
         end
         ACCUM: begin
            if (pulse_cnt_q == ROWS_CNT || (acc_add && pulse_cnt_q == ROWS_LAST))
               state_d = SEARCH;
         end
         SEARCH: begin
            if (srch_idx_q == LAST_CAND) state_d = DONE;
         end
         DONE: begin
            if (bus.res_ready) begin
               state_d = IDLE;
               acc_clr = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q <= '0;
         pulse_cnt_q <= '0;
         ref_base_q  <= '0;
         org_base_q  <= '0;
         ref_vld_q   <= 1'b0;
         org_vld_q   <= 1'b0;
         win_valid_q <= 1'b0;
         upper_q     <= '0;
         middle_q    <= '0;
         lower_q     <= '0;
         org_pix_q   <= '0;
         srch_idx_q  <= '0;
         best_idx_q  <= '0;
         best_sad_q  <= '0;
      end else begin
         if (state_q == IDLE && bus.start) begin
            ref_base_q <= bus.ref_base;
            org_base_q <= bus.org_base;
         end
         fetch_cnt_q <= (state_q == FETCH) ? fetch_cnt_q + 4'd1 : '0;
         ref_vld_q   <= bus.ref_rd_en;
         org_vld_q   <= bus.org_rd_en;
         win_valid_q <= org_vld_q;
         if (ref_vld_q) begin
            upper_q  <= middle_q;
            middle_q <= lower_q;
            lower_q  <= bus.ref_rd_data;
         end
         if (org_vld_q) org_pix_q <= bus.org_rd_data;
         if (acc_clr)      pulse_cnt_q <= '0;
         else if (acc_add) pulse_cnt_q <= pulse_cnt_q + 4'd1;
         srch_idx_q <= (state_q == SEARCH) ? srch_idx_q + 5'd1 : '0;
         // Strict less-than keeps the lowest index on ties; candidate 0 seeds the search.
         if (state_q == SEARCH && (srch_idx_q == '0 || acc_rd < best_sad_q)) begin
            best_idx_q <= srch_idx_q;
            best_sad_q <= acc_rd;
         end
      end
   end

   sad_acc_bank u_bank (
      .clk     (clk),
      .rst     (rst),
      .clr     (acc_clr),
      .add_en  (acc_add),
      .row_sad (bus.row_sad),
      .rd_idx  (srch_idx_q),
      .rd_sad  (acc_rd)
   );

   assign bus.cur_upper_pix  = upper_q;
   assign bus.cur_middle_pix = middle_q;
   assign bus.cur_lower_pix  = lower_q;
   assign bus.org_pix        = org_pix_q;
   assign bus.win_valid      = win_valid_q;
   assign bus.busy           = (state_q != IDLE);
   assign bus.res_valid      = (state_q == DONE);
   assign bus.best_idx       = best_idx_q;
   assign bus.best_sad       = best_sad_q;
   assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_frac_me_ctrl.sv
// Bench for frac_me_ctrl: directed passes against a cycle-indexed model of one ME pass.
module tb_frac_me_ctrl;
   import me_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   frac_me_ctrl_if mif();
   frac_me_ctrl dut (.clk(clk), .rst(rst), .bus(mif));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [63:0] ref_mem [256];
   logic [63:0] org_mem [256];
   logic [10:0] rnd_tab [ROWS][NCAND];

   // model of the pass in progress, indexed by cycles since FETCH entry
   bit          chk_on  = 1'b0;
   bit          pass_on = 1'b0;
   int          t_start, done_t, hs_t;
   logic [7:0]  m_rb, m_ob;
   logic [4:0]  exp_idx;
   logic [13:0] exp_sad;

   logic       pend_ref_en, pend_org_en;
   logic [7:0] pend_ref_addr, pend_org_addr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Advance one cycle; the line buffers answer the reads issued in the previous cycle.
   task automatic tick();
      @(posedge clk);
      #1;
      mif.ref_rd_data = pend_ref_en ? ref_mem[pend_ref_addr] : 64'h0;
      mif.org_rd_data = pend_org_en ? org_mem[pend_org_addr] : 64'h0;
      pend_ref_en   = mif.ref_rd_en;
      pend_ref_addr = mif.ref_rd_addr;
      pend_org_en   = mif.org_rd_en;
      pend_org_addr = mif.org_rd_addr;
   endtask

   function automatic logic [10:0] row_val(input int tc, input int r, input int k);
      case (tc)
         1:       return (k == 7) ? 11'd3 : 11'd100;
         2:       return (k == 3 || k == 12) ? 11'd50 : 11'(60 + 7*k + 3*r);
         3:       return rnd_tab[r][k];
         default: return (k == 18) ? 11'd20 : 11'(40 + k + r);
      endcase
   endfunction

   always @(negedge clk) begin : compare
      int t;
      if (chk_on) begin
         t = cyc - t_start;
         if (pass_on && t >= 0) begin
            chk("busy", mif.busy, 1'b1);
            chk("ref_en", mif.ref_rd_en, t < ROWS + 2);
            if (t < ROWS + 2) chk("ref_addr", mif.ref_rd_addr, 8'(m_rb + t));
            chk("org_en", mif.org_rd_en, t >= 2 && t < ROWS + 2);
            if (t >= 2 && t < ROWS + 2) chk("org_addr", mif.org_rd_addr, 8'(m_ob + t - 2));
            chk("win_valid", mif.win_valid, t >= 4 && t < ROWS + 4);
            if (t >= 4 && t < ROWS + 4) begin
               chk("upper",  mif.cur_upper_pix,  ref_mem[8'(m_rb + t - 4)]);
               chk("middle", mif.cur_middle_pix, ref_mem[8'(m_rb + t - 3)]);
               chk("lower",  mif.cur_lower_pix,  ref_mem[8'(m_rb + t - 2)]);
               chk("org_pix", mif.org_pix,       org_mem[8'(m_ob + t - 4)]);
            end
            chk("res_valid", mif.res_valid, t >= done_t);
            if (t >= done_t) begin
               chk("best_idx", mif.best_idx, exp_idx);
               chk("best_sad", mif.best_sad, exp_sad);
            end
         end else begin
            chk("idle_busy", mif.busy, 1'b0);
            chk("idle_ref_en", mif.ref_rd_en, 1'b0);
            chk("idle_org_en", mif.org_rd_en, 1'b0);
            chk("idle_win", mif.win_valid, 1'b0);
            chk("idle_res_valid", mif.res_valid, 1'b0);
         end
      end
   end

   task automatic run_pass(input logic [7:0] rb, input logic [7:0] ob, input int lat,
                           input int tc, input int hold, input int abort_t);
      int sums [NCAND];
      int win_cnt;
      for (int k = 0; k < NCAND; k++) begin
         sums[k] = 0;
         for (int r = 0; r < ROWS; r++) sums[k] += int'(row_val(tc, r, k));
      end
      exp_idx = 5'd0;
      exp_sad = 14'(sums[0]);
      for (int k = 1; k < NCAND; k++)
         if (sums[k] < int'(exp_sad)) begin
            exp_idx = 5'(k);
            exp_sad = 14'(sums[k]);
         end
      m_rb    = rb;
      m_ob    = ob;
      done_t  = 4 + ROWS + lat + NCAND;
      hs_t    = done_t + hold;
      win_cnt = 0;
      mif.start    = 1'b1;
      mif.ref_base = rb;
      mif.org_base = ob;
      t_start = cyc + 1;
      pass_on = 1'b1;
      tick();
      mif.start = 1'b0;
      for (int t = 0; t <= hs_t; t++) begin
         win_cnt += int'(mif.win_valid);
         if (tc == 1) begin
            if (t == 0) chk("lit_ref_first", mif.ref_rd_addr, 8'h10);
            if (t == 9) chk("lit_ref_last", mif.ref_rd_addr, 8'h19);
            if (t == 2) chk("lit_org_first", mif.org_rd_addr, 8'h40);
            if (t == 9) chk("lit_org_last", mif.org_rd_addr, 8'h47);
            if (t == 4) begin
               chk("lit_upper_r0", mif.cur_upper_pix, {8{8'h00}});
               chk("lit_middle_r0", mif.cur_middle_pix, {8{8'h01}});
               chk("lit_lower_r0", mif.cur_lower_pix, {8{8'h02}});
               chk("lit_org_r0", mif.org_pix, {8{8'hBF}});
            end
            if (t == 11) begin
               chk("lit_upper_r7", mif.cur_upper_pix, {8{8'h07}});
               chk("lit_lower_r7", mif.cur_lower_pix, {8{8'h09}});
            end
         end
         if (t == hs_t && abort_t < 0) begin
            chk("lit_res_held", mif.res_valid, 1'b1);
            if (tc == 1) begin
               chk("lit_t1_idx", mif.best_idx, 5'd7);
               chk("lit_t1_sad", mif.best_sad, 14'd24);
            end else if (tc == 2) begin
               chk("lit_tie_idx", mif.best_idx, 5'd3);
               chk("lit_tie_sad", mif.best_sad, 14'd400);
            end else if (tc == 4) begin
               chk("lit_fresh_idx", mif.best_idx, 5'd18);
               chk("lit_fresh_sad", mif.best_sad, 14'd160);
            end
         end
         mif.row_sad_valid = (t >= 4 + lat && t < 4 + ROWS + lat);
         mif.row_sad = '0;
         if (mif.row_sad_valid)
            for (int k = 0; k < NCAND; k++) mif.row_sad[k*RSAD_W +: RSAD_W] = row_val(tc, t - 4 - lat, k);
         mif.start     = 1'b0;
         mif.ref_base  = rb;
         mif.res_ready = (t == hs_t);
         if (tc == 3) begin
            if (t == 14 || t == done_t + 1) begin
               mif.start    = 1'b1;
               mif.ref_base = 8'hEE;
            end
            if (t == done_t - NCAND || t == done_t + 1) begin
               mif.row_sad_valid = 1'b1;
               for (int k = 0; k < NCAND; k++) mif.row_sad[k*RSAD_W +: RSAD_W] = 11'd2000;
            end
            if (t == done_t - 3) mif.res_ready = 1'b1;
         end
         rst = (t == abort_t);
         tick();
         if (t == abort_t) begin
            rst = 1'b0;
            break;
         end
      end
      mif.row_sad_valid = 1'b0;
      mif.res_ready     = 1'b0;
      mif.start         = 1'b0;
      pass_on           = 1'b0;
      if (abort_t < 0) chk("win_cycles", win_cnt, ROWS);
   endtask

   initial begin
      for (int a = 0; a < 256; a++) begin
         ref_mem[a] = {8{8'(a - 16)}};
         org_mem[a] = {8{~8'(a)}};
      end
      for (int r = 0; r < ROWS; r++)
         for (int k = 0; k < NCAND; k++) rnd_tab[r][k] = 11'($urandom_range(0, 2040));
      pend_ref_en = 1'b0;  pend_ref_addr = '0;
      pend_org_en = 1'b0;  pend_org_addr = '0;
      mif.start = 1'b0;  mif.ref_base = '0;  mif.org_base = '0;
      mif.ref_rd_data = '0;  mif.org_rd_data = '0;
      mif.row_sad = '0;  mif.row_sad_valid = 1'b0;  mif.res_ready = 1'b0;
      t_start = 0;  done_t = 0;  hs_t = 0;

      rst = 1'b1;
      repeat (3) tick();
      chk("rst_busy", mif.busy, 1'b0);
      chk("rst_res_valid", mif.res_valid, 1'b0);
      chk("rst_win", mif.win_valid, 1'b0);
      chk("rst_ref_en", mif.ref_rd_en, 1'b0);
      chk("rst_org_en", mif.org_rd_en, 1'b0);
      chk("rst_ref_addr", mif.ref_rd_addr, 8'h00);
      chk("rst_upper", mif.cur_upper_pix, 64'h0);
      chk("rst_org_pix", mif.org_pix, 64'h0);
      chk("rst_best_idx", mif.best_idx, 5'd0);
      chk("rst_best_sad", mif.best_sad, 14'd0);
      chk("rst_state", mif.dbg_state, IDLE);
      rst = 1'b0;
      chk_on = 1'b1;
      repeat (2) tick();

      run_pass(8'h10, 8'h40, 4, 1, 3, -1);   // single winner, latency 4
      repeat (3) tick();
      run_pass(8'h20, 8'h60, 1, 2, 0, -1);   // tie between 3 and 12
      repeat (2) tick();
      run_pass(8'h30, 8'h50, 6, 3, 5, -1);   // random SADs, stray start/valid/ready
      repeat (2) tick();
      run_pass(8'h10, 8'h40, 0, 4, 2, 6);    // reset mid-FETCH
      repeat (2) tick();
      run_pass(8'h80, 8'hC0, 0, 4, 2, -1);   // fresh pass after abort
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
